// File: rtl/ahbl_sram_pkg.sv
// Shared definitions for the AHB-Lite wait-state SRAM slave: bus encodings,
// the slave FSM state type and the byte-lane enable helper.
package ahbl_sram_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_t;

  // Little-endian lane enables. Low address bits below the size granule are
  // ignored, and any size above a word is handled as a word.
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] addr);
    case (size)
      HSIZE_BYTE: byte_en = 4'b0001 << addr;
      HSIZE_HALF: byte_en = addr[1] ? 4'b1100 : 4'b0011;
      default:    byte_en = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahbl_sram_array.sv
// Four 8-bit lanes, 2**AW words deep. One registered read port that holds its
// output while rd_en is low, one byte-enabled write port. A read and write to
// the same word on one edge returns the old data.
module ahbl_sram_array #(
  parameter int AW = 11
) (
  input  logic          HCLK,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  input  logic [3:0]    wr_be,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data
);

  localparam int DEPTH = 1 << AW;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;

    // Lane storage: byte write and registered read on the same clock edge.
    // NOTE: the storage array has no reset so it maps onto block RAM; only
    // control state around it is reset.
    always_ff @(posedge HCLK) begin
      if (wr_be[i]) mem[wr_addr] <= wr_data[8*i +: 8];
      if (rd_en)    rd_q <= mem[rd_addr];
    end

    assign rd_data[8*i +: 8] = rd_q;
  end

endmodule

// File: rtl/ahbl_sram.sv
// AHB-Lite SRAM slave with WAIT_STATES extra data-phase cycles and write-to-read
// byte forwarding. Define AHBL_SRAM_ERR_EN to answer misaligned or oversized
// transfers with a two-cycle ERROR; otherwise HRESP is tied OKAY and such
// transfers are aligned down. VERBOSE is accepted for compatibility and has no
// effect on the hardware.
module ahbl_sram_ws
  import ahbl_sram_pkg::*;
#(
  parameter int SIZE        = 8192,
  parameter int WAIT_STATES = 0,
  parameter int VERBOSE     = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int         AW  = $clog2(SIZE);
  localparam int         WAW = AW - 2;
  localparam logic [2:0] WS  = 3'(WAIT_STATES);

  state_t           state, state_nxt;
  logic [2:0]       wait_cnt;
  logic             dp_valid, dp_write;
  logic [WAW-1:0]   dp_addr;
  logic [3:0]       dp_be;
  logic             fwd_flag;
  logic [3:0]       fwd_be;
  logic [31:0]      fwd_data;
  logic [31:0]      rd_data;
  logic             accept, accept_ok, addr_err, close, commit, fwd_hit;

  // Upper address bits fold away (addresses alias modulo SIZE).
  logic unused_inputs;
  assign unused_inputs = ^{HADDR[31:AW], HTRANS[0], VERBOSE != 0};

  assign accept = HREADY & HSEL & HTRANS[1];

`ifdef AHBL_SRAM_ERR_EN
  assign addr_err = (HSIZE > HSIZE_WORD) ||
                    ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                    ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));
`else
  assign addr_err = 1'b0;
`endif

  assign accept_ok = accept & ~addr_err;
  // The edge ending an OK data phase; a write commits on it.
  assign close     = HREADYOUT & dp_valid;
  assign commit    = close & dp_write;
  assign fwd_hit   = commit & accept_ok & ~HWRITE & (HADDR[AW-1:2] == dp_addr);

  ahbl_sram_array #(.AW(WAW)) u_array (
    .HCLK    (HCLK),
    .rd_en   (accept_ok & ~HWRITE),
    .rd_addr (HADDR[AW-1:2]),
    .rd_data (rd_data),
    .wr_be   (commit ? dp_be : 4'b0000),
    .wr_addr (dp_addr),
    .wr_data (HWDATA)
  );

  // FSM state register and wait-state down-counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= ST_IDLE;
      wait_cnt <= 3'd0;
    end else begin
      state <= state_nxt;
      if (state == ST_WAIT)           wait_cnt <= wait_cnt - 3'd1;
      else if (accept_ok && WS != 0)  wait_cnt <= WS;
    end
  end

  // Next-state: new transfers start only from states that present HREADYOUT=1.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_ERR2: begin
        if (accept && addr_err)       state_nxt = ST_ERR1;
        else if (accept_ok && WS != 0) state_nxt = ST_WAIT;
        else                           state_nxt = ST_IDLE;
      end
      ST_WAIT: if (wait_cnt == 3'd1) state_nxt = ST_IDLE;
      ST_ERR1: state_nxt = ST_ERR2;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bus response decoded from the FSM state.
  // NOTE: defaults first so every path assigns every output and no latch forms.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state)
      ST_WAIT: HREADYOUT = 1'b0;
`ifdef AHBL_SRAM_ERR_EN
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      ST_ERR2: HRESP = 1'b1;
`endif
      default: ;
    endcase
  end

  // Data-phase context and the write-forwarding latch. Reset drops any
  // pending write because dp_valid clears before it can commit.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
      dp_be    <= 4'b0000;
      fwd_flag <= 1'b0;
      fwd_be   <= 4'b0000;
      fwd_data <= 32'h0;
    end else begin
      if (accept) begin
        dp_valid <= accept_ok;
        dp_write <= HWRITE;
        dp_addr  <= HADDR[AW-1:2];
        dp_be    <= byte_en(HSIZE, HADDR[1:0]);
        fwd_flag <= fwd_hit;
      end else if (close) begin
        dp_valid <= 1'b0;
        fwd_flag <= 1'b0;
      end
      if (fwd_hit) begin
        fwd_be   <= dp_be;
        fwd_data <= HWDATA;
      end
    end
  end

  // Read data only in the final read cycle, forwarded lanes over array output.
  always_comb begin
    HRDATA = 32'h0;
    if (close && !dp_write) begin
      for (int i = 0; i < 4; i++) begin
        HRDATA[8*i +: 8] = (fwd_flag && fwd_be[i]) ? fwd_data[8*i +: 8] : rd_data[8*i +: 8];
      end
    end
  end

endmodule
